// File: rtl/mac_atom_sched.sv
// mac_atom_sched: round-robin scheduler sharing one registered MAC stateful atom between requesters
module mac_atom_sched #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           i__reset,
  input  logic [NUM_REQ-1:0]             i__req_valid,
  output logic [NUM_REQ-1:0]             o__req_ready,
  input  logic [2*NUM_REQ-1:0]           i__req_op,
  input  logic [COUNT_WIDTH*NUM_REQ-1:0] i__req_pkt,
  input  logic                           i__cfg_wr,
  input  logic [COUNT_WIDTH-1:0]         i__cfg_constant,
  input  logic                           i__pause,
  input  logic                           i__clear,
  output logic                           o__resp_valid,
  output logic [ID_WIDTH-1:0]            o__resp_id,
  output logic [COUNT_WIDTH-1:0]         o__resp_old,
  output logic [COUNT_WIDTH-1:0]         o__resp_new,
  output logic [1:0]                     o__state,
  output logic [COUNT_WIDTH-1:0]         o__atom_constant,
  output logic [COUNT_WIDTH-1:0]         o__atom_pkt_1,
  output logic                           o__atom_sel1,
  output logic                           o__atom_sel2,
  input  logic [COUNT_WIDTH-1:0]         i__atom_write,
  input  logic [COUNT_WIDTH-1:0]         i__atom_read
);
  typedef enum logic [1:0] {INIT = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d, id1_q, id1_d, resp_id_q, resp_id_d, win, idx;
  logic [COUNT_WIDTH-1:0] cfg_q, cfg_d, old_q, old_d, new_q, new_d;
  logic v1_q, v1_d, resp_valid_q, resp_valid_d, found, gnt, clr;
  logic [1:0] op;
  logic [1:0] ops [NUM_REQ];
  logic [COUNT_WIDTH-1:0] pkts [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ops[g]  = i__req_op[2*g +: 2];
    assign pkts[g] = i__req_pkt[COUNT_WIDTH*g +: COUNT_WIDTH];
  end
  // first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    win = rr_ptr_q;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && i__req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // grant, atom controls (NOP = READ when idle, CLR in INIT/reset) and next-state values
  always_comb begin
    gnt = found && state_q == RUN && !i__pause && !i__clear && !i__reset;
    clr = state_q == INIT || i__reset;
    op = ops[win];
    o__req_ready = gnt ? NUM_REQ'(1) << win : '0;
    o__atom_sel1 = clr || (gnt && op == 2'b11);
    o__atom_sel2 = gnt && op == 2'b10;
    o__atom_constant = (gnt && op == 2'b01) ? cfg_q : COUNT_WIDTH'(1);
    o__atom_pkt_1 = (gnt && op == 2'b10) ? pkts[win] : '0;
    state_d = i__clear ? INIT : i__pause ? PAUSE : RUN;
    rr_ptr_d = !gnt ? rr_ptr_q : win == ID_WIDTH'(NUM_REQ - 1) ? '0 : win + 1'b1;
    cfg_d = i__cfg_wr ? i__cfg_constant : cfg_q;
    v1_d = gnt;
    id1_d = win;
    resp_valid_d = v1_q;
    resp_id_d = v1_q ? id1_q : resp_id_q;
    old_d = v1_q ? i__atom_read : old_q;
    new_d = v1_q ? i__atom_write : new_q;
  end
  // state, pointer, constant and two-stage response pipeline
  always_ff @(posedge clk) begin
    if (i__reset) begin
      state_q <= INIT;
      rr_ptr_q <= '0;
      cfg_q <= '0;
      v1_q <= 1'b0;
      id1_q <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      old_q <= '0;
      new_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cfg_q <= cfg_d;
      v1_q <= v1_d;
      id1_q <= id1_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      old_q <= old_d;
      new_q <= new_d;
    end
  end
  assign o__state = state_q;
  assign o__resp_valid = resp_valid_q;
  assign o__resp_id = resp_id_q;
  assign o__resp_old = old_q;
  assign o__resp_new = new_q;
endmodule

// File: tb/tb_mac_atom_sched.sv
// tb_mac_atom_sched: directed self-checking bench with a behavioural MAC atom
module tb_mac_atom_sched;
  logic clk = 1'b0, rst = 1'b1, cfg_wr = 1'b0, pause = 1'b0, clr = 1'b0;
  logic [3:0] valid = '0, ready;
  logic [7:0] op = '0;
  logic [127:0] pkt = '0;
  logic [31:0] cfg = '0, resp_old, resp_new, a_constant, a_pkt, a_write, a_read;
  logic resp_valid, a_sel1, a_sel2;
  logic [1:0] resp_id, state;
  logic [31:0] m_c = 32'd1, m_p = '0, m_st = '0, seed_val = '0;
  logic m_s1 = 1'b1, m_s2 = 1'b0, seed_en = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mac_atom_sched dut (
    .clk(clk), .i__reset(rst), .i__req_valid(valid), .o__req_ready(ready),
    .i__req_op(op), .i__req_pkt(pkt), .i__cfg_wr(cfg_wr), .i__cfg_constant(cfg),
    .i__pause(pause), .i__clear(clr), .o__resp_valid(resp_valid), .o__resp_id(resp_id),
    .o__resp_old(resp_old), .o__resp_new(resp_new), .o__state(state),
    .o__atom_constant(a_constant), .o__atom_pkt_1(a_pkt), .o__atom_sel1(a_sel1),
    .o__atom_sel2(a_sel2), .i__atom_write(a_write), .i__atom_read(a_read)
  );
  // behavioural atom: registered controls, state updated every cycle, optional preload
  assign a_write = m_s1 ? '0 : m_st * (m_s2 ? m_p : m_c);
  assign a_read = m_st;
  always @(posedge clk) begin
    m_c <= a_constant;
    m_p <= a_pkt;
    m_s1 <= a_sel1;
    m_s2 <= a_sel2;
    m_st <= seed_en ? seed_val : a_write;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_resp(input string tag, input int id, input logic [31:0] o, input logic [31:0] n);
    chk({tag, "_v"}, 32'(resp_valid), 32'd1);
    chk({tag, "_id"}, 32'(resp_id), 32'(id));
    chk({tag, "_old"}, resp_old, o);
    chk({tag, "_new"}, resp_new, n);
  endtask
  task automatic req(input int r, input logic [1:0] opc, input logic [31:0] p);
    valid = 4'b1 << r;
    op[2*r +: 2] = opc;
    pkt[32*r +: 32] = p;
  endtask
  task automatic seed(input logic [31:0] v);
    seed_en = 1'b1;
    seed_val = v;
    tick();
    seed_en = 1'b0;
  endtask
  initial begin
    // 1: reset, INIT then RUN, READ on zero state
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_resp_v", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sel1", 32'(a_sel1), 32'd1);
    rst = 1'b0;
    #1;
    chk("init_state", 32'(state), 32'd0);
    tick();
    chk("run_state", 32'(state), 32'd1);
    tick();
    tick();
    req(0, 2'b00, 0);
    #1;
    chk("read_ready", 32'(ready), 32'b0001);
    chk("nop_const", a_constant, 32'd1);
    tick();
    valid = '0;
    chk("read_lat1", 32'(resp_valid), 32'd0);
    tick();
    chk_resp("read0", 0, 0, 0);
    tick();
    chk("read_pulse", 32'(resp_valid), 32'd0);
    // 2: cfg=3, MULP 2 then MULC back-to-back on state 5; truncation chain
    cfg_wr = 1'b1;
    cfg = 32'd3;
    seed(32'd5);
    cfg_wr = 1'b0;
    req(1, 2'b10, 32'd2);
    #1;
    chk("mulp_ready", 32'(ready), 32'b0010);
    chk("mulp_sel2", 32'(a_sel2), 32'd1);
    chk("mulp_pkt", a_pkt, 32'd2);
    tick();
    req(1, 2'b01, 0);
    #1;
    chk("mulc_ready", 32'(ready), 32'b0010);
    chk("mulc_const", a_constant, 32'd3);
    tick();
    valid = '0;
    chk_resp("mulp", 1, 32'd5, 32'd10);
    tick();
    chk_resp("mulc", 1, 32'd10, 32'd30);
    seed(32'd1);
    req(0, 2'b10, 32'h10000);
    tick();
    tick();
    valid = '0;
    chk_resp("trunc1", 0, 32'd1, 32'h10000);
    tick();
    chk_resp("trunc2", 0, 32'h10000, 32'd0);
    // 3: round-robin order 0,1,2,3,0 and response ids 2 cycles later
    req(3, 2'b00, 0);
    tick();
    valid = '0;
    tick();
    tick();
    op = '0;
    for (int k = 0; k < 6; k++) begin
      valid = k < 5 ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) chk($sformatf("rr_ready%0d", k), 32'(ready), 32'(4'b1 << (k % 4)));
      tick();
      if (k >= 1) begin
        chk($sformatf("rr_rv%0d", k), 32'(resp_valid), 32'd1);
        chk($sformatf("rr_id%0d", k), 32'(resp_id), 32'((k - 1) % 4));
      end
    end
    // 4: pause while req2 in flight
    seed(32'd9);
    req(2, 2'b00, 0);
    #1;
    chk("p_ready2", 32'(ready), 32'b0100);
    tick();
    pause = 1'b1;
    valid = 4'b1111;
    #1;
    chk("p_noready", 32'(ready), 32'd0);
    chk("p_nop_sel1", 32'(a_sel1), 32'd0);
    chk("p_nop_sel2", 32'(a_sel2), 32'd0);
    chk("p_nop_const", a_constant, 32'd1);
    tick();
    chk("p_state", 32'(state), 32'd2);
    chk_resp("p_resp", 2, 32'd9, 32'd9);
    tick();
    chk("p_noready2", 32'(ready), 32'd0);
    chk("p_resp_off", 32'(resp_valid), 32'd0);
    pause = 1'b0;
    valid = '0;
    tick();
    chk("p_run", 32'(state), 32'd1);
    req(3, 2'b00, 0);
    tick();
    valid = '0;
    tick();
    chk_resp("p_hold", 3, 32'd9, 32'd9);
    // 5: cfg_wr in same cycle as MULC
    seed(32'd2);
    req(3, 2'b01, 0);
    cfg_wr = 1'b1;
    cfg = 32'd7;
    #1;
    chk("cfg_old_const", a_constant, 32'd3);
    tick();
    cfg_wr = 1'b0;
    #1;
    chk("cfg_new_const", a_constant, 32'd7);
    tick();
    valid = '0;
    chk_resp("cfg_mulc1", 3, 32'd2, 32'd6);
    tick();
    chk_resp("cfg_mulc2", 3, 32'd6, 32'd42);
    // 6a: clear mid-stream
    req(0, 2'b00, 0);
    tick();
    clr = 1'b1;
    #1;
    chk("clr_noready", 32'(ready), 32'd0);
    tick();
    clr = 1'b0;
    #1;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_sel1", 32'(a_sel1), 32'd1);
    chk("clr_init_noready", 32'(ready), 32'd0);
    chk_resp("clr_inflight", 0, 32'd42, 32'd42);
    tick();
    chk("clr_run", 32'(state), 32'd1);
    chk("clr_ready", 32'(ready), 32'b0001);
    tick();
    valid = '0;
    tick();
    chk_resp("clr_read", 0, 0, 0);
    // 6b: reset mid-stream with cfg_wr and clear in the same cycle
    seed(32'd4);
    req(1, 2'b00, 0);
    tick();
    valid = '0;
    rst = 1'b1;
    cfg_wr = 1'b1;
    cfg = 32'd9;
    clr = 1'b1;
    tick();
    rst = 1'b0;
    cfg_wr = 1'b0;
    clr = 1'b0;
    #1;
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_rv", 32'(resp_valid), 32'd0);
    chk("mrst_sel1", 32'(a_sel1), 32'd1);
    tick();
    chk("mrst_stale", 32'(resp_valid), 32'd0);
    chk("mrst_run", 32'(state), 32'd1);
    valid = 4'b1111;
    op = 8'b01_01_01_01;
    #1;
    chk("mrst_rr0", 32'(ready), 32'b0001);
    chk("mrst_cfg0", a_constant, 32'd0);
    tick();
    valid = '0;
    tick();
    chk_resp("mrst_read", 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
